bayer_window_ctrl: RTL and testbench
====================================

BAYER_WINDOW_CTRL -- requirements
Module: bayer_window_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 16, meaning pixels per line (>=2).
REQ-002 SHALL have parameter IMG_H, default 16, meaning lines per frame (>=2).
REQ-003 SHALL have ports: clk  in  1  system clock, the one clock; n_rst  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: start  in  1  frame-start pulse; busy  out  1  high outside IDLE.
REQ-005 SHALL have ports: in_pixel  in  8  white-balanced raw pixel, raster order; in_valid  in  1; in_ready  out  1.
REQ-006 SHALL have ports: wb_1, wb_2, wb_3, wb_4  out  8 each  window top-left, top-right, bottom-left, bottom-right.
REQ-007 SHALL have ports: row, col  out  1 each  parity of window top-left row/column, feeding the Bayer-to-RGGB mux.
REQ-008 SHALL have ports: out_valid  in... out  1; out_ready  in  1; frame_done  out  1  one-cycle pulse; err  out  1  sticky protocol error.

Function
REQ-009 SHALL implement FSM IDLE -> FILL -> RUN -> DRAIN -> IDLE.
REQ-010 IDLE: in_ready=0; start=1 SHALL clear row/col counters and go to FILL next cycle.
REQ-011 FILL: each accepted pixel (in_valid&in_ready) SHALL be written to the line buffer at col_cnt; after pixel IMG_W-1, go to RUN.
REQ-012 RUN: pixel accepted at (r,c) with r>=1 and c>=1 SHALL load a window {line_buf[c-1], line_buf[c], prev_pixel, in_pixel} into wb_1..wb_4 with row=(r-1)[0], col=(c-1)[0], out_valid=1 on the next cycle (latency 1).
REQ-013 Each accepted pixel SHALL overwrite line_buf[c] only after its old value is used; prev_pixel holds the previously accepted pixel of the same line.
REQ-014 Column 0 of each line SHALL produce no window; windows per frame SHALL be (IMG_W-1)*(IMG_H-1).
REQ-015 col_cnt SHALL wrap IMG_W-1 -> 0 and increment row_cnt; accepting pixel (IMG_H-1, IMG_W-1) SHALL go to DRAIN.
REQ-016 in_ready SHALL be 1 in FILL and RUN only when !out_valid || out_ready (output register free or being emptied same cycle).
REQ-017 out_valid SHALL hold and wb_*/row/col SHALL stay stable until out_valid&out_ready; a new window loaded the same cycle SHALL replace it without a bubble.
REQ-018 DRAIN: in_ready=0; when final window handshakes, frame_done SHALL pulse that cycle... registered, asserted the following cycle, and FSM SHALL enter IDLE.
REQ-019 start outside IDLE SHALL be ignored by the FSM.
REQ-020 busy SHALL equal (state != IDLE).

Reset
REQ-021 n_rst low SHALL asynchronously force state=IDLE, counters=0, wb_1..wb_4=0, row=col=0, out_valid=0, frame_done=0, err=0, in_ready=0.
REQ-022 Reset mid-frame SHALL discard the partial frame; line buffer contents need not be cleared.

Configuration
REQ-023 With BAYER_WINDOW_ERR_EN defined, err SHALL set on start while busy or in_valid in IDLE/DRAIN, and clear only on reset.
REQ-024 Without BAYER_WINDOW_ERR_EN, err SHALL be constant 0 and no detection logic SHALL be built.

Structure
REQ-025 Package bayer_pkg SHALL hold the state enum, pixel_t (8-bit) typedef and the window struct {tl,tr,bl,br,row,col}.
REQ-026 Sub-module line_buffer (IMG_W x 8, one write/one read per cycle, same address) SHALL hold the previous line; counters and FSM stay in bayer_window_ctrl.

Verification (IMG_W=4, IMG_H=3, pixels 0..11 unless stated)
REQ-027 Continuous stream, out_ready=1 -> windows (0,1,4,5)r0c0, (1,2,5,6)r0c1, (2,3,6,7)r0c0, (4,5,8,9)r1c0, (5,6,9,10)r1c1, (6,7,10,11)r1c0; frame_done once, 1 cycle after last handshake.
REQ-028 out_ready=0 for 5 cycles after first window -> in_ready=0 after next window loads, window (0,1,4,5) held stable, no window lost or duplicated.
REQ-029 n_rst pulse after pixel 6 -> all outputs 0, state IDLE; subsequent start and pixels 0..11 reproduce REQ-027 sequence exactly.
REQ-030 start asserted during RUN -> stream unaffected; err=1 with BAYER_WINDOW_ERR_EN, err=0 without.
REQ-031 in_valid toggling every other cycle -> same six windows as REQ-027; out_valid never asserted in FILL.

Source files
------------

// File: rtl/bayer_pkg.sv
// rtl/bayer_pkg.sv - shared types for the Bayer 2x2 window controller
package bayer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    typedef logic [7:0] pixel_t;

    typedef struct packed {
        pixel_t tl;
        pixel_t tr;
        pixel_t bl;
        pixel_t br;
        logic   row;
        logic   col;
    } window_t;

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - single-line pixel store, async read and sync write at one shared address
module line_buffer
    import bayer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  pixel_t        wdata,
    output pixel_t        rdata
);

    pixel_t mem [DEPTH];

    // Read returns the old entry during a write cycle, giving read-before-write per pixel.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/bayer_window_ctrl.sv
// rtl/bayer_window_ctrl.sv - raster pixel stream to 2x2 Bayer windows with valid/ready output
// Optional protocol error detection enabled by defining BAYER_WINDOW_ERR_EN.
module bayer_window_ctrl
    import bayer_pkg::*;
#(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    output logic       busy,
    input  logic [7:0] in_pixel,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] wb_1,
    output logic [7:0] wb_2,
    output logic [7:0] wb_3,
    output logic [7:0] wb_4,
    output logic       row,
    output logic       col,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_done,
    output logic       err
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    pixel_t        prev_q, prev_d;
    pixel_t        top_prev_q, top_prev_d;
    window_t       win_q, win_d;
    logic          out_valid_q, out_valid_d;
    logic          frame_done_q, frame_done_d;
    pixel_t        lb_rdata;
    logic          accept;
    logic          last_col;
    logic          last_row;

    assign in_ready = ((state_q == ST_FILL) || (state_q == ST_RUN)) &&
                      (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign last_col = (col_q == CW'(IMG_W - 1));
    assign last_row = (row_q == RW'(IMG_H - 1));

    line_buffer #(
        .DEPTH (IMG_W),
        .AW    (CW)
    ) u_line_buffer (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (in_pixel),
        .rdata (lb_rdata)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        prev_d       = prev_q;
        top_prev_d   = top_prev_q;
        win_d        = win_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    col_d   = '0;
                    row_d   = '0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL, ST_RUN: begin
                if (accept) begin
                    prev_d     = in_pixel;
                    top_prev_d = lb_rdata;
                    // Window parity is that of (r-1, c-1), i.e. the inverted LSBs.
                    if (state_q == ST_RUN && col_q != '0) begin
                        win_d = '{tl: top_prev_q, tr: lb_rdata, bl: prev_q, br: in_pixel,
                                  row: ~row_q[0], col: ~col_q[0]};
                        out_valid_d = 1'b1;
                    end
                    if (last_col) begin
                        col_d = '0;
                        if (state_q == ST_RUN && last_row) begin
                            state_d = ST_DRAIN;
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = ST_RUN;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            prev_q       <= '0;
            top_prev_q   <= '0;
            win_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            prev_q       <= prev_d;
            top_prev_q   <= top_prev_d;
            win_q        <= win_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef BAYER_WINDOW_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((start && busy) ||
            (in_valid && (state_q == ST_IDLE || state_q == ST_DRAIN))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy       = (state_q != ST_IDLE);
    assign wb_1       = win_q.tl;
    assign wb_2       = win_q.tr;
    assign wb_3       = win_q.bl;
    assign wb_4       = win_q.br;
    assign row        = win_q.row;
    assign col        = win_q.col;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bayer_window_ctrl.sv
// tb/tb_bayer_window_ctrl.sv - scoreboard and table checks for bayer_window_ctrl at 4x3
module tb_bayer_window_ctrl;

    localparam int W = 4;
    localparam int H = 3;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic [7:0] in_pixel = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] wb_1, wb_2, wb_3, wb_4;
    logic       row, col;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       frame_done;
    logic       err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         pix;
        logic [7:0] tl, tr, bl, br;
        logic       row, col;
    } vec_t;

    vec_t        vecs [6];
    logic [33:0] exp_q [$];
    logic [33:0] got_q [$];

    always #5 clk = ~clk;

    bayer_window_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .busy       (busy),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wb_1       (wb_1),
        .wb_2       (wb_2),
        .wb_3       (wb_3),
        .wb_4       (wb_4),
        .row        (row),
        .col        (col),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .err        (err)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [33:0] cur_win();
        return {wb_1, wb_2, wb_3, wb_4, row, col};
    endfunction

    task automatic chk_reset_state(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_in_ready"}, in_ready, 0);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_frame_done"}, frame_done, 0);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_window"}, cur_win(), 0);
    endtask

    // mode 0: continuous, 1: 5-cycle stall on first window, 2: in_valid every other cycle,
    // 3: continuous with start pulsed mid-RUN. Stops early after npix pixels when npix < NPIX.
    task automatic run_frame(input int mode, input int npix);
        int          pix = 0;
        int          cyc = 0;
        int          stall = 0;
        int          last_hs = -10;
        int          fd_cnt = 0;
        bit          seen_first = 0;
        bit          done = 0;
        logic [33:0] held = '0;
        logic [33:0] e;
        int          r, c;
        exp_q.delete();
        got_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        while (!done && cyc < 300) begin
            if (cyc != 0) @(negedge clk);
            in_valid = (pix < npix) && (mode != 2 || cyc[0] == 1'b0);
            in_pixel = 8'(pix);
            start    = (mode == 3 && pix == 6);
            if (mode == 1 && !seen_first && out_valid) begin
                seen_first = 1;
                stall = 5;
                held = cur_win();
            end
            out_ready = (stall == 0);
            #1;
            if (pix <= 5) chk("no_early_out_valid", out_valid, 0);
            if (stall > 0) begin
                chk("stall_in_ready", in_ready, 0);
                chk("stall_window_held", cur_win(), held);
                stall--;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_window", cur_win(), 34'h3ffffffff);
                end else begin
                    e = exp_q.pop_front();
                    chk("scoreboard_window", cur_win(), e);
                end
                got_q.push_back(cur_win());
                last_hs = cyc;
            end
            if (in_valid && in_ready) begin
                r = pix / W;
                c = pix % W;
                if (r >= 1 && c >= 1) begin
                    exp_q.push_back({8'(pix - W - 1), 8'(pix - W), 8'(pix - 1), 8'(pix),
                                     1'((r - 1) & 1), 1'((c - 1) & 1)});
                end
                pix++;
            end
            if (frame_done) begin
                fd_cnt++;
                chk("frame_done_latency", cyc, last_hs + 1);
                done = 1;
            end
            if (npix < NPIX && pix == npix) done = 1;
            cyc++;
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        if (!done) chk("frame_timeout", cyc, 0);
        if (npix == NPIX) begin
            @(negedge clk);
            chk("frame_done_once", fd_cnt, 1);
            chk("frame_done_pulse_ends", frame_done, 0);
            chk("idle_after_frame", busy, 0);
            chk("window_count", got_q.size(), 6);
            chk("scoreboard_empty", exp_q.size(), 0);
            for (int i = 0; i < 6; i++) begin
                if (i < got_q.size()) begin
                    chk($sformatf("table_win%0d", i), got_q[i],
                        {vecs[i].tl, vecs[i].tr, vecs[i].bl, vecs[i].br, vecs[i].row, vecs[i].col});
                end
            end
        end
    endtask

    initial begin
        vecs[0] = '{pix: 5,  tl: 0, tr: 1, bl: 4,  br: 5,  row: 0, col: 0};
        vecs[1] = '{pix: 6,  tl: 1, tr: 2, bl: 5,  br: 6,  row: 0, col: 1};
        vecs[2] = '{pix: 7,  tl: 2, tr: 3, bl: 6,  br: 7,  row: 0, col: 0};
        vecs[3] = '{pix: 9,  tl: 4, tr: 5, bl: 8,  br: 9,  row: 1, col: 0};
        vecs[4] = '{pix: 10, tl: 5, tr: 6, bl: 9,  br: 10, row: 1, col: 1};
        vecs[5] = '{pix: 11, tl: 6, tr: 7, bl: 10, br: 11, row: 1, col: 0};

        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        n_rst = 1'b1;
        @(negedge clk);
        chk("idle_no_start", busy, 0);

        run_frame(0, NPIX);
        run_frame(1, NPIX);

        run_frame(0, 7);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk_reset_state("midframe_reset");
        @(negedge clk);
        n_rst = 1'b1;
        run_frame(0, NPIX);

        run_frame(2, NPIX);

        run_frame(3, NPIX);
`ifdef BAYER_WINDOW_ERR_EN
        chk("err_start_in_run", err, 1);
`else
        chk("err_start_in_run", err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
